// File: rtl/serial_inst_rom_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_inst_rom_if
// Brief    : Serial address/data stream and parallel programming port bundle
//            for the bit-serial instruction store.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_inst_rom_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  addr_start;
    logic                  addr_in;
    logic                  data_out;
    logic                  data_valid;
    logic                  busy;
    logic                  proto_err;
    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;

    modport master (
        output addr_start, addr_in, prog_we, prog_addr, prog_data,
        input  data_out, data_valid, busy, proto_err
    );

    modport slave (
        input  addr_start, addr_in, prog_we, prog_addr, prog_data,
        output data_out, data_valid, busy, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/serial_inst_rom.sv
`default_nettype none
// ============================================================================
// Module   : serial_inst_rom
// Brief    : Bit-serial word store: MSB-first address in, MSB-first word out,
//            contents loaded through a parallel programming port.
// Revision : 1.0 - initial release
// ============================================================================
module serial_inst_rom #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_reset,
    serial_inst_rom_if.slave bus
);
    localparam int c_cnt_max = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int c_cnt_w   = $clog2(c_cnt_max);
    localparam int c_idx_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]  c_depth    = DEPTH[ADDR_WIDTH:0];
    localparam logic [c_cnt_w-1:0]   c_addr_last = c_cnt_w'(ADDR_WIDTH - 1);
    localparam logic [c_cnt_w-1:0]   c_data_last = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RX_ADDR = 2'd1,
        ST_TX_DATA = 2'd2
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt,        w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr_sr,    w_addr_sr_nxt;
    logic [DATA_WIDTH-1:0] r_tx_sr,      w_tx_sr_nxt;
    logic                  r_data_valid, w_data_valid_nxt;
    logic                  r_busy,       w_busy_nxt;
    logic                  r_proto_err,  w_proto_err_nxt;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr_full;
    logic                  w_rd_hit;
    logic                  w_wr_hit;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_addr_full = {r_addr_sr[ADDR_WIDTH-2:0], bus.addr_in};
    assign w_rd_hit    = ({1'b0, w_addr_full} < c_depth);
    assign w_wr_hit    = ({1'b0, bus.prog_addr} < c_depth);
    // The array read uses pre-edge contents, so a same-edge write is not seen.
    assign w_rd_word   = w_rd_hit ? r_mem[w_addr_full[c_idx_w-1:0]] : '0;

    always_ff @(posedge sys_clk) begin
        if (bus.prog_we && w_wr_hit) begin
            r_mem[bus.prog_addr[c_idx_w-1:0]] <= bus.prog_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_addr_sr    <= '0;
            r_tx_sr      <= '0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_addr_sr    <= w_addr_sr_nxt;
            r_tx_sr      <= w_tx_sr_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_proto_err  <= w_proto_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_addr_sr_nxt   = r_addr_sr;
        w_tx_sr_nxt     = r_tx_sr;
        w_proto_err_nxt = r_proto_err;

        case (r_state)
            ST_IDLE: begin
                if (bus.addr_start) begin
                    w_addr_sr_nxt = {{(ADDR_WIDTH-1){1'b0}}, bus.addr_in};
                    w_cnt_nxt     = c_cnt_one;
                    w_state_nxt   = ST_RX_ADDR;
                end
            end
            ST_RX_ADDR: begin
                if (bus.addr_start) begin
                    w_proto_err_nxt = 1'b1;
                end
                w_addr_sr_nxt = w_addr_full;
                if (r_cnt == c_addr_last) begin
                    w_tx_sr_nxt = w_rd_word;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_TX_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            ST_TX_DATA: begin
                // Shifting in zeros leaves the register clear after the last bit.
                w_tx_sr_nxt = {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
                if (r_cnt == c_data_last) begin
                    if (bus.addr_start) begin
                        w_addr_sr_nxt = {{(ADDR_WIDTH-1){1'b0}}, bus.addr_in};
                        w_cnt_nxt     = c_cnt_one;
                        w_state_nxt   = ST_RX_ADDR;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                    if (bus.addr_start) begin
                        w_proto_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_data_valid_nxt = (w_state_nxt == ST_TX_DATA);
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
    end

    assign bus.data_out   = r_tx_sr[DATA_WIDTH-1];
    assign bus.data_valid = r_data_valid;
    assign bus.busy       = r_busy;
    assign bus.proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_inst_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_inst_rom
// Brief    : Directed self-checking bench for serial_inst_rom (DEPTH=200).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_inst_rom;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic sys_reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_inst_rom_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    serial_inst_rom #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(200)) dut (
        .sys_clk   (clk),
        .sys_reset (sys_reset),
        .bus       (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.addr_start = 1'b0;
        bus.addr_in    = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
    endtask

    task automatic prog(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick();
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        sys_reset = 1'b1;
        tick();
        tick();
        sys_reset = 1'b0;
    endtask

    // Drives address bits; counts cycles where data_valid was seen high.
    task automatic send_addr(input logic [AW-1:0] a, input logic skip_first, input int err_bit,
                             input logic wr_last, input logic [DW-1:0] wdata, output int vcnt);
        vcnt = 0;
        for (int i = AW - 1; i >= 0; i--) begin
            if (!(skip_first && i == AW - 1)) begin
                if (bus.data_valid === 1'b1) vcnt++;
                bus.addr_start = (i == AW - 1) || (i == err_bit);
                bus.addr_in    = a[i];
                bus.prog_we    = wr_last && (i == 0);
                bus.prog_addr  = a;
                bus.prog_data  = wdata;
                tick();
            end
        end
        clear_inputs();
    endtask

    // Collects DW output bits; optionally chains the next request's first bit.
    task automatic recv_word(input int err_idx, input int wr_idx, input logic [AW-1:0] wr_addr,
                             input logic [DW-1:0] wr_data, input logic chain,
                             input logic [AW-1:0] next_addr, output logic [DW-1:0] w, output int vcnt);
        w    = '0;
        vcnt = 0;
        for (int i = 0; i < DW; i++) begin
            w = {w[DW-2:0], bus.data_out};
            if (bus.data_valid === 1'b1) vcnt++;
            bus.addr_start = (i == err_idx) || (chain && i == DW - 1);
            bus.addr_in    = (chain && i == DW - 1) ? next_addr[AW-1] : 1'b0;
            bus.prog_we    = (i == wr_idx);
            bus.prog_addr  = wr_addr;
            bus.prog_data  = wr_data;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.data_out !== 1'b0)   begin n_err++; $display("FAIL rst_data_out got %b exp 0", bus.data_out); end
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_err++; $display("FAIL rst_data_valid got %b exp 0", bus.data_valid); end
        n_cmp++; if (bus.busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        n_cmp++; if (bus.proto_err !== 1'b0)  begin n_err++; $display("FAIL rst_proto_err got %b exp 0", bus.proto_err); end
    endtask

    task automatic test_basic_read();
        logic [DW-1:0] w;
        int gap, v;
        prog(8'h5A, 16'hBEEF);
        send_addr(8'h5A, 1'b0, -1, 1'b0, '0, gap);
        n_cmp++; if (gap !== 0) begin n_err++; $display("FAIL basic_early_valid got %0d exp 0", gap); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_tx got %b exp 1", bus.busy); end
        recv_word(-1, -1, '0, '0, 1'b0, '0, w, v);
        n_cmp++; if (w !== 16'hBEEF) begin n_err++; $display("FAIL basic_word got %h exp beef", w); end
        n_cmp++; if (v !== 16) begin n_err++; $display("FAIL basic_valid_cycles got %0d exp 16", v); end
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_end got %b exp 0", bus.data_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got %b exp 0", bus.busy); end
        n_cmp++; if (bus.data_out !== 1'b0) begin n_err++; $display("FAIL basic_dout_end got %b exp 0", bus.data_out); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w;
        int gap, v;
        prog(8'h01, 16'h8001);
        prog(8'h02, 16'h7FFE);
        send_addr(8'h01, 1'b0, -1, 1'b0, '0, gap);
        recv_word(-1, -1, '0, '0, 1'b1, 8'h02, w, v);
        n_cmp++; if (w !== 16'h8001) begin n_err++; $display("FAIL b2b_word1 got %h exp 8001", w); end
        n_cmp++; if (v !== 16) begin n_err++; $display("FAIL b2b_valid1 got %0d exp 16", v); end
        send_addr(8'h02, 1'b1, -1, 1'b0, '0, gap);
        n_cmp++; if (gap !== 0) begin n_err++; $display("FAIL b2b_gap_valid got %0d exp 0", gap); end
        recv_word(-1, -1, '0, '0, 1'b0, '0, w, v);
        n_cmp++; if (w !== 16'h7FFE) begin n_err++; $display("FAIL b2b_word2 got %h exp 7ffe", w); end
        n_cmp++; if (v !== 16) begin n_err++; $display("FAIL b2b_valid2 got %0d exp 16", v); end
        n_cmp++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL b2b_proto_err got %b exp 0", bus.proto_err); end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] w;
        int gap, v;
        prog(8'h48, 16'h1111);
        prog(8'hC7, 16'h2222);
        prog(8'hC8, 16'hFFFF);
        send_addr(8'hC8, 1'b0, -1, 1'b0, '0, gap);
        recv_word(-1, -1, '0, '0, 1'b0, '0, w, v);
        n_cmp++; if (w !== 16'h0000) begin n_err++; $display("FAIL oor_word got %h exp 0000", w); end
        n_cmp++; if (v !== 16) begin n_err++; $display("FAIL oor_valid got %0d exp 16", v); end
        send_addr(8'hC7, 1'b0, -1, 1'b0, '0, gap);
        recv_word(-1, -1, '0, '0, 1'b0, '0, w, v);
        n_cmp++; if (w !== 16'h2222) begin n_err++; $display("FAIL oor_last_word got %h exp 2222", w); end
        send_addr(8'h48, 1'b0, -1, 1'b0, '0, gap);
        recv_word(-1, -1, '0, '0, 1'b0, '0, w, v);
        n_cmp++; if (w !== 16'h1111) begin n_err++; $display("FAIL oor_alias_word got %h exp 1111", w); end
    endtask

    task automatic test_proto_err();
        logic [DW-1:0] w;
        int gap, v;
        do_reset();
        send_addr(8'h5A, 1'b0, 4, 1'b0, '0, gap);
        n_cmp++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL perr_rx got %b exp 1", bus.proto_err); end
        recv_word(2, -1, '0, '0, 1'b0, '0, w, v);
        n_cmp++; if (w !== 16'hBEEF) begin n_err++; $display("FAIL perr_word got %h exp beef", w); end
        n_cmp++; if (v !== 16) begin n_err++; $display("FAIL perr_valid got %0d exp 16", v); end
        tick(); tick(); tick();
        n_cmp++; if (bus.proto_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky got %b exp 1", bus.proto_err); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL perr_idle_busy got %b exp 0", bus.busy); end
        do_reset();
        n_cmp++; if (bus.proto_err !== 1'b0) begin n_err++; $display("FAIL perr_clear got %b exp 0", bus.proto_err); end
    endtask

    task automatic test_reset_mid_tx();
        logic [DW-1:0] w;
        int gap, v;
        send_addr(8'h5A, 1'b0, -1, 1'b0, '0, gap);
        for (int i = 0; i < 4; i++) tick();
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        n_cmp++; if (bus.data_out !== 1'b0)   begin n_err++; $display("FAIL abort_dout got %b exp 0", bus.data_out); end
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b exp 0", bus.data_valid); end
        n_cmp++; if (bus.busy !== 1'b0)       begin n_err++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
        send_addr(8'h5A, 1'b0, -1, 1'b0, '0, gap);
        recv_word(-1, -1, '0, '0, 1'b0, '0, w, v);
        n_cmp++; if (w !== 16'hBEEF) begin n_err++; $display("FAIL abort_retry_word got %h exp beef", w); end
        n_cmp++; if (v !== 16) begin n_err++; $display("FAIL abort_retry_valid got %0d exp 16", v); end
    endtask

    task automatic test_read_before_write();
        logic [DW-1:0] w;
        int gap, v;
        prog(8'h10, 16'h1234);
        send_addr(8'h10, 1'b0, -1, 1'b1, 16'hAAAA, gap);
        recv_word(-1, 5, 8'h10, 16'hAAAA, 1'b0, '0, w, v);
        n_cmp++; if (w !== 16'h1234) begin n_err++; $display("FAIL rbw_inflight got %h exp 1234", w); end
        send_addr(8'h10, 1'b0, -1, 1'b0, '0, gap);
        recv_word(-1, -1, '0, '0, 1'b0, '0, w, v);
        n_cmp++; if (w !== 16'hAAAA) begin n_err++; $display("FAIL rbw_next got %h exp aaaa", w); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_read();
        test_back_to_back();
        test_out_of_range();
        test_proto_err();
        test_reset_mid_tx();
        test_read_before_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
